// File: rtl/ravenoc_pkg.sv
// Shared RaveNoC definitions: flit type encoding, default sizing and
// wormhole arbiter FSM state encodings.
package ravenoc_pkg;

  localparam int N_VIRT_CHN   = 3;
  localparam int FLIT_WIDTH   = 34;
  localparam int PKT_SZ_WIDTH = 8;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/vc_wormhole_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr_i upward with wrap,
// or fixed priority (highest index wins) when VC_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef VC_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end
`else
  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    int cand;
    cand  = 0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_i) + k) % N;
      if (req_i[cand]) begin
        idx_o = IDX_W'(cand);
        any_o = 1'b1;
      end
    end
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end
`endif

endmodule

// File: rtl/vc_wormhole_arbiter.sv
// Wormhole output-link scheduler: a head flit locks the link to its VC until the
// tail transfers. Define VC_FIXED_PRIO_EN for fixed-priority (highest VC) arbitration.
module vc_wormhole_arbiter #(
  parameter int N_VIRT_CHN   = ravenoc_pkg::N_VIRT_CHN,
  parameter int FLIT_WIDTH   = ravenoc_pkg::FLIT_WIDTH,
  parameter int PKT_SZ_WIDTH = ravenoc_pkg::PKT_SZ_WIDTH
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [N_VIRT_CHN-1:0]            vc_valid_i,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] vc_flit_i,
  output logic [N_VIRT_CHN-1:0]            vc_ready_o,
  output logic [FLIT_WIDTH-1:0]            flit_o,
  output logic                             valid_o,
  output logic [$clog2(N_VIRT_CHN)-1:0]    vc_id_o,
  input  logic                             ready_i,
  output logic                             locked_o,
  output logic                             err_o
);
  import ravenoc_pkg::*;

  localparam int IDX_W = $clog2(N_VIRT_CHN);

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        lock_vc_q, lock_vc_d;
  logic [PKT_SZ_WIDTH-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        rr_ptr_q;

  logic [N_VIRT_CHN-1:0]   head_req;
  logic [N_VIRT_CHN-1:0]   arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [IDX_W-1:0]        sel;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  flit_type_t              sel_type;
  logic                    xfer;

  // Only head flits may open a new packet on the link.
  always_comb begin
    head_req = '0;
    for (int i = 0; i < N_VIRT_CHN; i++) begin
      head_req[i] = vc_valid_i[i] &&
                    (vc_flit_i[i*FLIT_WIDTH + FLIT_WIDTH - 1 -: 2] == HEAD_FLIT);
    end
  end

  rr_arbiter #(.N(N_VIRT_CHN), .IDX_W(IDX_W)) u_arb (
    .req_i (head_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    sel        = (state_q == ST_LOCKED) ? lock_vc_q : arb_idx;
    sel_flit   = vc_flit_i[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];
    sel_type   = flit_type_t'(sel_flit[FLIT_WIDTH-1 -: 2]);
    valid_o    = 1'b0;
    vc_ready_o = '0;
    if (!arst) begin
      if (state_q == ST_LOCKED) begin
        valid_o               = vc_valid_i[lock_vc_q];
        vc_ready_o[lock_vc_q] = vc_valid_i[lock_vc_q] & ready_i;
      end else begin
        valid_o    = arb_any;
        vc_ready_o = arb_gnt & {N_VIRT_CHN{ready_i}};
      end
    end
    xfer = valid_o & ready_i;
  end

  assign flit_o   = sel_flit;
  assign vc_id_o  = sel;
  assign locked_o = (state_q == ST_LOCKED);
  assign err_o    = err_q;

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    if (xfer) begin
      if (state_q == ST_IDLE) begin
        if (sel_flit[PKT_SZ_WIDTH-1:0] != '0) begin
          cnt_d     = sel_flit[PKT_SZ_WIDTH-1:0];
          lock_vc_d = arb_idx;
          state_d   = ST_LOCKED;
        end
      end else begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        // Any framing violation releases the link so the next packet can proceed.
        case (sel_type)
          TAIL_FLIT: begin
            err_d   = (cnt_q != PKT_SZ_WIDTH'(1));
            state_d = ST_IDLE;
          end
          HEAD_FLIT: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
          default: begin
            if (cnt_q == PKT_SZ_WIDTH'(1)) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      lock_vc_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

`ifdef VC_FIXED_PRIO_EN
  assign rr_ptr_q = '0;
`else
  logic [IDX_W-1:0] rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && state_q == ST_IDLE) begin
      rr_ptr_d = (arb_idx == IDX_W'(N_VIRT_CHN - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: tb/tb_vc_wormhole_arbiter.sv
// Self-checking bench for vc_wormhole_arbiter: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_vc_wormhole_arbiter;
  import ravenoc_pkg::*;

  localparam int N  = 3;
  localparam int FW = 34;
  localparam int PW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    vc_valid_i;
  logic [N*FW-1:0] vc_flit_i;
  logic [N-1:0]    vc_ready_o;
  logic [FW-1:0]   flit_o;
  logic            valid_o;
  logic [IW-1:0]   vc_id_o;
  logic            ready_i;
  logic            locked_o;
  logic            err_o;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] cur_flit [N];
  int            g_body   [N];
  bit            g_tail   [N];

  vc_wormhole_arbiter #(.N_VIRT_CHN(N), .FLIT_WIDTH(FW), .PKT_SZ_WIDTH(PW)) dut (
    .clk        (clk),
    .arst       (arst),
    .vc_valid_i (vc_valid_i),
    .vc_flit_i  (vc_flit_i),
    .vc_ready_o (vc_ready_o),
    .flit_o     (flit_o),
    .valid_o    (valid_o),
    .vc_id_o    (vc_id_o),
    .ready_i    (ready_i),
    .locked_o   (locked_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(logic [1:0] t, logic [23:0] pl, logic [7:0] sz);
    return {t, pl, sz};
  endfunction

  task automatic set_vc(int i, logic v, logic [FW-1:0] f);
    vc_valid_i[i]         = v;
    vc_flit_i[i*FW +: FW] = f;
  endtask

  task automatic clear_vcs();
    vc_valid_i = '0;
    vc_flit_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    clear_vcs();
    tick();
    arst = 1'b0;
  endtask

  // Upstream packet source per VC; a malformed packet is occasionally produced.
  task automatic gen_next(int i);
    logic [7:0]  sz;
    logic [23:0] pl;
    pl = 24'($urandom);
    if (g_body[i] > 0) begin
      cur_flit[i] = mk(BODY_FLIT, pl, 8'($urandom));
      g_body[i]--;
    end else if (g_tail[i]) begin
      cur_flit[i] = mk(TAIL_FLIT, pl, 8'($urandom));
      g_tail[i]   = 1'b0;
    end else begin
      sz          = 8'($urandom_range(0, 4));
      cur_flit[i] = mk(HEAD_FLIT, pl, sz);
      if (sz != 0) begin
        g_body[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, sz + 1)) : sz - 1;
        g_tail[i] = 1'b1;
      end
    end
  endtask

  task automatic flush(int i);
    g_body[i] = 0;
    g_tail[i] = 1'b0;
    gen_next(i);
  endtask

  task automatic test_reset();
    logic [IW-1:0] exp_id;
    arst    = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_vc(i, 1'b1, mk(HEAD_FLIT, 24'h100 + 24'(i), 8'd0));
    tick();
    for (int c = 0; c < 10; c++) begin
      #2;
      checks++;
      if (valid_o !== 1'b0 || vc_ready_o !== 3'b000 || locked_o !== 1'b0 || err_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: valid=%b ready=%b locked=%b err=%b, want 0 000 0 0",
                 c, valid_o, vc_ready_o, locked_o, err_o);
      end
      tick();
    end
    arst = 1'b0;
`ifdef VC_FIXED_PRIO_EN
    exp_id = 2'd2;
`else
    exp_id = 2'd0;
`endif
    #2;
    checks++;
    if (valid_o !== 1'b1 || vc_id_o !== exp_id || vc_ready_o !== (3'b001 << exp_id)) begin
      failures++;
      $display("[TB] FAIL reset_release_grant: valid=%b id=%0d ready=%b, want 1 %0d %b",
               valid_o, vc_id_o, vc_ready_o, exp_id, 3'b001 << exp_id);
    end
    tick();
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] f;
    do_reset();
    ready_i = 1'b1;
    f = mk(HEAD_FLIT, 24'hBEEFBE, 8'd0);
    set_vc(1, 1'b1, f);
    #2;
    checks++;
    if (valid_o !== 1'b1 || flit_o !== f || vc_id_o !== 2'd1 || vc_ready_o !== 3'b010) begin
      failures++;
      $display("[TB] FAIL single_flit_grant: valid=%b flit=%h id=%0d ready=%b, want 1 %h 1 010",
               valid_o, flit_o, vc_id_o, vc_ready_o, f);
    end
    tick();
    set_vc(1, 1'b0, '0);
    set_vc(2, 1'b1, mk(HEAD_FLIT, 24'h222222, 8'd0));
    #2;
    checks++;
    if (locked_o !== 1'b0 || valid_o !== 1'b1 || vc_id_o !== 2'd2 || vc_ready_o !== 3'b100) begin
      failures++;
      $display("[TB] FAIL single_flit_next: locked=%b valid=%b id=%0d ready=%b, want 0 1 2 100",
               locked_o, valid_o, vc_id_o, vc_ready_o);
    end
    tick();
  endtask

  task automatic test_wormhole();
    logic [FW-1:0] pkt [4];
    do_reset();
    ready_i = 1'b1;
    pkt[0] = mk(HEAD_FLIT, 24'hA00000, 8'd3);
    pkt[1] = mk(BODY_FLIT, 24'hA11111, 8'h11);
    pkt[2] = mk(BODY_FLIT, 24'hA22222, 8'h22);
    pkt[3] = mk(TAIL_FLIT, 24'hA33333, 8'h33);
    for (int b = 0; b < 4; b++) begin
      set_vc(0, 1'b1, pkt[b]);
      if (b == 1) set_vc(2, 1'b1, mk(HEAD_FLIT, 24'hC00000, 8'd0));
      #2;
      checks++;
      if (valid_o !== 1'b1 || vc_id_o !== 2'd0 || flit_o !== pkt[b] || vc_ready_o !== 3'b001 ||
          locked_o !== (b != 0)) begin
        failures++;
        $display("[TB] FAIL wormhole_flit%0d: valid=%b id=%0d flit=%h ready=%b locked=%b, want 1 0 %h 001 %b",
                 b, valid_o, vc_id_o, flit_o, vc_ready_o, locked_o, pkt[b], b != 0);
      end
      tick();
    end
    set_vc(0, 1'b0, '0);
    #2;
    checks++;
    if (locked_o !== 1'b0 || err_o !== 1'b0 || valid_o !== 1'b1 || vc_id_o !== 2'd2 || vc_ready_o !== 3'b100) begin
      failures++;
      $display("[TB] FAIL wormhole_after_tail: locked=%b err=%b valid=%b id=%0d ready=%b, want 0 0 1 2 100",
               locked_o, err_o, valid_o, vc_id_o, vc_ready_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [IW-1:0] exp_id;
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_vc(i, 1'b1, mk(HEAD_FLIT, 24'h300000 + 24'(i), 8'd0));
    for (int c = 0; c < 6; c++) begin
`ifdef VC_FIXED_PRIO_EN
      exp_id = 2'd2;
`else
      exp_id = IW'(c % N);
`endif
      #2;
      checks++;
      if (valid_o !== 1'b1 || vc_id_o !== exp_id || vc_ready_o !== (3'b001 << exp_id)) begin
        failures++;
        $display("[TB] FAIL round_robin_grant%0d: valid=%b id=%0d ready=%b, want 1 %0d %b",
                 c, valid_o, vc_id_o, vc_ready_o, exp_id, 3'b001 << exp_id);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] body;
    do_reset();
    ready_i = 1'b1;
    set_vc(1, 1'b1, mk(HEAD_FLIT, 24'h510000, 8'd2));
    #2;
    checks++;
    if (vc_id_o !== 2'd1 || vc_ready_o !== 3'b010) begin
      failures++;
      $display("[TB] FAIL backpressure_head: id=%0d ready=%b, want 1 010", vc_id_o, vc_ready_o);
    end
    tick();
    body = mk(BODY_FLIT, 24'h5B0D11, 8'h77);
    set_vc(1, 1'b1, body);
    set_vc(0, 1'b1, mk(HEAD_FLIT, 24'h500000, 8'd0));
    set_vc(2, 1'b1, mk(HEAD_FLIT, 24'h520000, 8'd0));
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if (valid_o !== 1'b1 || vc_id_o !== 2'd1 || flit_o !== body || vc_ready_o !== 3'b000 || locked_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL backpressure_hold%0d: valid=%b id=%0d flit=%h ready=%b locked=%b, want 1 1 %h 000 1",
                 c, valid_o, vc_id_o, flit_o, vc_ready_o, locked_o, body);
      end
      tick();
    end
    ready_i = 1'b1;
    #2;
    checks++;
    if (vc_ready_o !== 3'b010 || flit_o !== body) begin
      failures++;
      $display("[TB] FAIL backpressure_resume: ready=%b flit=%h, want 010 %h", vc_ready_o, flit_o, body);
    end
    tick();
    set_vc(1, 1'b1, mk(TAIL_FLIT, 24'h5E0000, 8'h00));
    #2;
    checks++;
    if (vc_ready_o !== 3'b010 || locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL backpressure_tail: ready=%b locked=%b, want 010 1", vc_ready_o, locked_o);
    end
    tick();
    set_vc(1, 1'b0, '0);
    #2;
    checks++;
    if (err_o !== 1'b0 || locked_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_count_kept: err=%b locked=%b, want 0 0", err_o, locked_o);
    end
    tick();
  endtask

  task automatic test_framing();
    do_reset();
    ready_i = 1'b1;
    set_vc(0, 1'b1, mk(HEAD_FLIT, 24'h600000, 8'd3));
    tick();
    set_vc(0, 1'b1, mk(BODY_FLIT, 24'h611111, 8'h01));
    tick();
    set_vc(0, 1'b1, mk(TAIL_FLIT, 24'h622222, 8'h02));
    #2;
    checks++;
    if (vc_ready_o !== 3'b001 || err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL framing_short_tail_accept: ready=%b err=%b, want 001 0", vc_ready_o, err_o);
    end
    tick();
    clear_vcs();
    #2;
    checks++;
    if (err_o !== 1'b1 || locked_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL framing_err_pulse: err=%b locked=%b, want 1 0", err_o, locked_o);
    end
    tick();
    #2;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL framing_err_single_cycle: err=%b, want 0", err_o);
    end
    set_vc(0, 1'b1, mk(HEAD_FLIT, 24'h630000, 8'd3));
    tick();
    set_vc(0, 1'b1, mk(BODY_FLIT, 24'h640000, 8'h00));
    #2;
    checks++;
    if (locked_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL framing_locked_before_reset: locked=%b, want 1", locked_o);
    end
    arst = 1'b1;
    tick();
    arst = 1'b0;
    clear_vcs();
    set_vc(1, 1'b1, mk(HEAD_FLIT, 24'h650000, 8'd0));
    #2;
    checks++;
    if (locked_o !== 1'b0 || valid_o !== 1'b1 || vc_id_o !== 2'd1 || vc_ready_o !== 3'b010) begin
      failures++;
      $display("[TB] FAIL framing_reset_drops_lock: locked=%b valid=%b id=%0d ready=%b, want 0 1 1 010",
               locked_o, valid_o, vc_id_o, vc_ready_o);
    end
    tick();
  endtask

  // Reference model tracks link ownership and flits still owed by the open packet.
  task automatic test_random();
    bit            m_locked, m_err, ev;
    int            m_vc, m_rem, m_rr, g, c;
    logic [N-1:0]  er;
    logic [1:0]    t;
    do_reset();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_vc     = 0;
    m_rem    = 0;
    m_rr     = 0;
    for (int i = 0; i < N; i++) flush(i);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      arst    = ($urandom_range(0, 79) == 0);
      ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_vc(i, ($urandom_range(0, 3) != 0), cur_flit[i]);
      #2;
      g = -1;
      if (!m_locked) begin
        for (int k = 0; k < N; k++) begin
`ifdef VC_FIXED_PRIO_EN
          c = N - 1 - k;
`else
          c = (m_rr + k) % N;
`endif
          if (g < 0 && vc_valid_i[c] && cur_flit[c][FW-1 -: 2] == HEAD_FLIT) g = c;
        end
      end else if (vc_valid_i[m_vc]) begin
        g = m_vc;
      end
      if (arst) g = -1;
      ev = (g >= 0);
      er = '0;
      if (ev && ready_i) er[g] = 1'b1;
      checks++;
      if (valid_o !== ev || vc_ready_o !== er) begin
        failures++;
        $display("[TB] FAIL random_handshake cyc %0d: valid=%b ready=%b, want %b %b", cyc, valid_o, vc_ready_o, ev, er);
      end
      if (ev) begin
        checks++;
        if (vc_id_o !== IW'(g) || flit_o !== cur_flit[g]) begin
          failures++;
          $display("[TB] FAIL random_data cyc %0d: id=%0d flit=%h, want %0d %h", cyc, vc_id_o, flit_o, g, cur_flit[g]);
        end
      end
      checks++;
      if (locked_o !== m_locked || err_o !== m_err) begin
        failures++;
        $display("[TB] FAIL random_status cyc %0d: locked=%b err=%b, want %b %b", cyc, locked_o, err_o, m_locked, m_err);
      end
      @(posedge clk);
      if (arst) begin
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_rr     = 0;
        for (int i = 0; i < N; i++) flush(i);
      end else begin
        m_err = 1'b0;
        if (ev && ready_i) begin
          t = cur_flit[g][FW-1 -: 2];
          if (!m_locked) begin
            m_rr = (g + 1) % N;
            if (cur_flit[g][PW-1:0] != 0) begin
              m_locked = 1'b1;
              m_vc     = g;
              m_rem    = int'(cur_flit[g][PW-1:0]);
            end
            gen_next(g);
          end else begin
            if (t == TAIL_FLIT) begin
              m_err    = (m_rem != 1);
              m_locked = 1'b0;
            end else if (t == HEAD_FLIT || m_rem == 1) begin
              m_err    = 1'b1;
              m_locked = 1'b0;
            end else begin
              m_rem--;
            end
            if (m_err) flush(g);
            else       gen_next(g);
          end
        end
      end
      #1;
    end
    arst = 1'b0;
  endtask

  initial begin
    arst    = 1'b1;
    ready_i = 1'b0;
    clear_vcs();
    test_reset();
    test_single_flit();
    test_wormhole();
    test_round_robin();
    test_backpressure();
    test_framing();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
